// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory controller: access width codes, FSM states,
// byte-count decode and load-result extension.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        W_B = 2'b00,
        W_H = 2'b01,
        W_W = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LS_RD = 2'd1,
        LS_WR = 2'd2,
        IF_RD = 2'd3
    } state_e;

    localparam logic REQ_LOAD  = 1'b0;
    localparam logic REQ_STORE = 1'b1;

    // Undefined width code 2'b10 is treated as a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] w);
        case (width_e'(w))
            W_B:     byte_count = 3'd1;
            W_H:     byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] w,
                                           input logic sext);
        case (width_e'(w))
            W_B:     extend = {{24{sext & raw[7]}}, raw[7:0]};
            W_H:     extend = {{16{sext & raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between LSB/IFetch (master) and the memory controller (slave),
// including the byte-wide RAM port the controller drives.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ROB_W  = 32
);
    logic              lsb_req_flag;
    logic [1:0]        lsb_req_width;
    logic              lsb_req_type;
    logic              lsb_req_sext;
    logic [ADDR_W-1:0] lsb_req_addr;
    logic [XLEN-1:0]   lsb_req_data;
    logic [ROB_W-1:0]  lsb_req_rob_id;
    logic              lsb_done_flag;
    logic              ld_cdb_flag;
    logic [ROB_W-1:0]  ld_cdb_rob_id;
    logic [XLEN-1:0]   ld_cdb_val;

    logic              if_req_flag;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_done_flag;
    logic [XLEN-1:0]   if_inst;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport master (
        output lsb_req_flag, lsb_req_width, lsb_req_type, lsb_req_sext,
               lsb_req_addr, lsb_req_data, lsb_req_rob_id,
        input  lsb_done_flag, ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val,
        output if_req_flag, if_req_addr,
        input  if_done_flag, if_inst,
        output mem_din,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  lsb_req_flag, lsb_req_width, lsb_req_type, lsb_req_sext,
               lsb_req_addr, lsb_req_data, lsb_req_rob_id,
        output lsb_done_flag, ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val,
        input  if_req_flag, if_req_addr,
        output if_done_flag, if_inst,
        input  mem_din,
        output mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl_byte_seq.sv
// Byte sequencer: walks k = 0..n over one access, drives the registered RAM address/write
// byte and assembles read bytes (each arrives one cycle after its address).
module mem_byte_seq #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              start,
    input  logic              run,
    input  logic              abort,
    input  logic              is_write,
    input  logic [2:0]        n_bytes,
    input  logic [ADDR_W-1:0] base,
    input  logic [XLEN-1:0]   wdata,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    output logic              last,
    output logic [31:0]       rdata
);

    logic [2:0]        k;
    logic [2:0]        k_next;
    logic [2:0]        n_r;
    logic              wr_r;
    logic [ADDR_W-1:0] base_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rbuf;
    logic [7:0]        wbyte;

    always_comb begin
        k_next = k + 3'd1;
        last   = wr_r ? (k == n_r - 3'd1) : (k == n_r);
        wbyte  = 8'(wdata_r >> {k_next, 3'b000});
    end

    // rdata already contains the byte arriving this cycle, so the final edge can use it directly.
    always_comb begin
        rdata = rbuf;
        for (int unsigned i = 0; i < 4; i++) begin
            if (k != 3'd0 && 3'(i) == k - 3'd1) begin
                rdata[8*i +: 8] = mem_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            n_r      <= '0;
            wr_r     <= 1'b0;
            base_r   <= '0;
            wdata_r  <= '0;
            rbuf     <= '0;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
            mem_dout <= '0;
        end else if (rdy) begin
            if (start) begin
                k        <= '0;
                n_r      <= n_bytes;
                wr_r     <= is_write;
                base_r   <= base;
                wdata_r  <= wdata[31:0];
                rbuf     <= '0;
                mem_a    <= base;
                mem_wr   <= is_write;
                mem_dout <= wdata[7:0];
            end else if (run && !abort) begin
                k <= k_next;
                if (!wr_r) begin
                    rbuf <= rdata;
                end
                if (k_next < n_r) begin
                    mem_a    <= base_r + ADDR_W'(k_next);
                    mem_wr   <= wr_r;
                    mem_dout <= wbyte;
                end else begin
                    mem_wr <= 1'b0;
                end
            end else begin
                mem_wr <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: latches one LSB request and one instruction fetch, arbitrates (LSB first),
// runs each access through the byte sequencer and returns done pulses plus the load CDB value.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ROB_W  = 32,
    parameter logic [1:0]  IO_HI  = 2'b11
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic jump_wrong_stall,
    input  logic io_buffer_full,
    mem_ctrl_if.slave bus
);

    state_e            state, state_n;

    logic              lsb_pend;
    logic [1:0]        lsb_w;
    logic              lsb_t;
    logic              lsb_s;
    logic [ADDR_W-1:0] lsb_a;
    logic [XLEN-1:0]   lsb_d;
    logic [ROB_W-1:0]  lsb_rob;

    logic              if_pend;
    logic [ADDR_W-1:0] if_a;

    logic              lsb_done_r;
    logic              cdb_flag_r;
    logic [ROB_W-1:0]  cdb_rob_r;
    logic [XLEN-1:0]   cdb_val_r;
    logic              if_done_r;
    logic [XLEN-1:0]   if_inst_r;

    logic              lsb_cap, lsb_avail, if_cap, if_avail, io_block;
    logic [1:0]        cur_w;
    logic              cur_t;
    logic [ADDR_W-1:0] cur_a;
    logic [XLEN-1:0]   cur_d;
    logic [ADDR_W-1:0] cur_if_a;

    logic              seq_start, seq_wr, seq_abort, seq_last;
    logic [2:0]        seq_n;
    logic [ADDR_W-1:0] seq_base;
    logic [31:0]       seq_rdata;
    logic              fin_lsb, fin_if;

    // A request can start in the same cycle it is captured, so selection falls through to the inputs.
    always_comb begin
        lsb_cap   = bus.lsb_req_flag && !lsb_pend && !lsb_done_r;
        lsb_avail = lsb_pend || lsb_cap;
        cur_w     = lsb_pend ? lsb_w : bus.lsb_req_width;
        cur_t     = lsb_pend ? lsb_t : bus.lsb_req_type;
        cur_a     = lsb_pend ? lsb_a : bus.lsb_req_addr;
        cur_d     = lsb_pend ? lsb_d : bus.lsb_req_data;
        io_block  = (cur_t == REQ_STORE) && (cur_a[17:16] == IO_HI) && io_buffer_full;
        if_cap    = bus.if_req_flag && !if_pend && !if_done_r && !jump_wrong_stall;
        if_avail  = (if_pend || if_cap) && !jump_wrong_stall;
        cur_if_a  = if_pend ? if_a : bus.if_req_addr;
    end

    always_comb begin
        state_n   = state;
        seq_start = 1'b0;
        seq_wr    = 1'b0;
        seq_abort = 1'b0;
        seq_base  = cur_a;
        seq_n     = byte_count(cur_w);
        fin_lsb   = 1'b0;
        fin_if    = 1'b0;
        unique case (state)
            IDLE: begin
                // A blocked IO store still owns the port: fetch waits behind it.
                if (lsb_avail) begin
                    if (!io_block) begin
                        seq_start = 1'b1;
                        seq_wr    = cur_t;
                        state_n   = (cur_t == REQ_STORE) ? LS_WR : LS_RD;
                    end
                end else if (if_avail) begin
                    seq_start = 1'b1;
                    seq_base  = cur_if_a;
                    seq_n     = 3'd4;
                    state_n   = IF_RD;
                end
            end
            LS_RD, LS_WR: begin
                if (seq_last) begin
                    state_n = IDLE;
                    fin_lsb = 1'b1;
                end
            end
            IF_RD: begin
                if (jump_wrong_stall) begin
                    state_n   = IDLE;
                    seq_abort = 1'b1;
                end else if (seq_last) begin
                    state_n = IDLE;
                    fin_if  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    mem_byte_seq #(
        .ADDR_W (ADDR_W),
        .XLEN   (XLEN)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .start    (seq_start),
        .run      (state != IDLE),
        .abort    (seq_abort),
        .is_write (seq_wr),
        .n_bytes  (seq_n),
        .base     (seq_base),
        .wdata    (cur_d),
        .mem_din  (bus.mem_din),
        .mem_a    (bus.mem_a),
        .mem_wr   (bus.mem_wr),
        .mem_dout (bus.mem_dout),
        .last     (seq_last),
        .rdata    (seq_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lsb_pend   <= 1'b0;
            lsb_w      <= '0;
            lsb_t      <= 1'b0;
            lsb_s      <= 1'b0;
            lsb_a      <= '0;
            lsb_d      <= '0;
            lsb_rob    <= '0;
            if_pend    <= 1'b0;
            if_a       <= '0;
            lsb_done_r <= 1'b0;
            cdb_flag_r <= 1'b0;
            cdb_rob_r  <= '0;
            cdb_val_r  <= '0;
            if_done_r  <= 1'b0;
            if_inst_r  <= '0;
        end else if (rdy) begin
            state      <= state_n;
            lsb_done_r <= fin_lsb;
            cdb_flag_r <= fin_lsb && (lsb_t == REQ_LOAD);
            if (fin_lsb && lsb_t == REQ_LOAD) begin
                cdb_rob_r <= lsb_rob;
                cdb_val_r <= XLEN'(extend(seq_rdata, lsb_w, lsb_s));
            end
            if (lsb_cap) begin
                lsb_pend <= 1'b1;
                lsb_w    <= bus.lsb_req_width;
                lsb_t    <= bus.lsb_req_type;
                lsb_s    <= bus.lsb_req_sext;
                lsb_a    <= bus.lsb_req_addr;
                lsb_d    <= bus.lsb_req_data;
                lsb_rob  <= bus.lsb_req_rob_id;
            end else if (fin_lsb) begin
                lsb_pend <= 1'b0;
            end
            if_done_r <= fin_if;
            if (fin_if) begin
                if_inst_r <= XLEN'(seq_rdata);
            end
            if (jump_wrong_stall) begin
                if_pend <= 1'b0;
            end else if (if_cap) begin
                if_pend <= 1'b1;
                if_a    <= bus.if_req_addr;
            end else if (fin_if) begin
                if_pend <= 1'b0;
            end
        end
    end

    assign bus.lsb_done_flag = lsb_done_r;
    assign bus.ld_cdb_flag   = cdb_flag_r;
    assign bus.ld_cdb_rob_id = cdb_rob_r;
    assign bus.ld_cdb_val    = cdb_val_r;
    assign bus.if_done_flag  = if_done_r;
    assign bus.if_inst       = if_inst_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model, LSB/IF transactions with hand-computed
// data and cycle-exact latencies, IO back-pressure, flush and wrap cases.
module tb_mem_ctrl;

    localparam logic [1:0] WB = 2'b00;
    localparam logic [1:0] WH = 2'b01;
    localparam logic [1:0] WW = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic jws = 1'b0;
    logic iof = 1'b0;

    mem_ctrl_if #(.ADDR_W(32), .XLEN(32), .ROB_W(32)) bus ();

    mem_ctrl #(
        .ADDR_W (32),
        .XLEN   (32),
        .ROB_W  (32),
        .IO_HI  (2'b11)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .jump_wrong_stall (jws),
        .io_buffer_full   (iof),
        .bus              (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:262143];

    always @(posedge clk) begin
        if (rst) begin
            ram[18'h00100] <= 8'h78; ram[18'h00101] <= 8'h56;
            ram[18'h00102] <= 8'h34; ram[18'h00103] <= 8'h12;
            ram[18'h00080] <= 8'h80;
            ram[18'h08001] <= 8'h01; ram[18'h08002] <= 8'h80;
            ram[18'h00040] <= 8'hEF; ram[18'h00041] <= 8'hBE;
            ram[18'h00042] <= 8'hAD; ram[18'h00043] <= 8'hDE;
            ram[18'h00000] <= 8'h13; ram[18'h00001] <= 8'h05;
            ram[18'h00002] <= 8'h50; ram[18'h00003] <= 8'h00;
            ram[18'h3FFFF] <= 8'hF0;
        end else if (rdy) begin
            if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
        end
        if (rdy) bus.mem_din <= ram[bus.mem_a[17:0]];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    int          d_cycle, n_done, n_cdb, n_wr, fd, n_ifd;
    logic        d_cdb;
    logic [31:0] d_val, d_rob, a_c2, f_inst;
    int          wr_cyc [8];
    logic [31:0] wr_a   [8];
    logic [7:0]  wr_d   [8];

    // LSB holds its flag through the done cycle and drops it one cycle later.
    task automatic lsb_op(input logic [1:0] w, input logic t, input logic s,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rob,
                          input int io_hold);
        d_cycle = -1; n_done = 0; n_cdb = 0; n_wr = 0; d_cdb = 1'b0;
        d_val = '0; d_rob = '0; a_c2 = '0;
        @(negedge clk);
        bus.lsb_req_flag   = 1'b1;
        bus.lsb_req_width  = w;
        bus.lsb_req_type   = t;
        bus.lsb_req_sext   = s;
        bus.lsb_req_addr   = a;
        bus.lsb_req_data   = d;
        bus.lsb_req_rob_id = rob;
        iof = (io_hold > 0);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.mem_wr) begin
                if (n_wr < 8) begin
                    wr_cyc[n_wr] = c; wr_a[n_wr] = bus.mem_a; wr_d[n_wr] = bus.mem_dout;
                end
                n_wr++;
            end
            if (bus.lsb_done_flag) begin
                n_done++;
                if (d_cycle < 0) begin
                    d_cycle = c; d_cdb = bus.ld_cdb_flag;
                    d_val = bus.ld_cdb_val; d_rob = bus.ld_cdb_rob_id;
                end
            end
            if (bus.ld_cdb_flag) n_cdb++;
            if (c == 2) a_c2 = bus.mem_a;
            if (c == io_hold) iof = 1'b0;
            if (d_cycle > 0 && c == d_cycle + 1) bus.lsb_req_flag = 1'b0;
        end
        bus.lsb_req_flag = 1'b0;
        iof = 1'b0;
    endtask

    task automatic if_op(input logic [31:0] a, input int flush_at);
        fd = -1; n_ifd = 0; f_inst = '0;
        @(negedge clk);
        bus.if_req_flag = 1'b1;
        bus.if_req_addr = a;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.if_done_flag) begin
                n_ifd++;
                if (fd < 0) begin fd = c; f_inst = bus.if_inst; end
            end
            if (c == flush_at) begin jws = 1'b1; bus.if_req_flag = 1'b0; end
            if (c == flush_at + 1) jws = 1'b0;
            if (fd == c) bus.if_req_flag = 1'b0;
        end
        bus.if_req_flag = 1'b0;
        jws = 1'b0;
    endtask

    initial begin
        int bad;
        int ld, nrst;
        bus.lsb_req_flag = 1'b0; bus.lsb_req_width = '0; bus.lsb_req_type = 1'b0;
        bus.lsb_req_sext = 1'b0; bus.lsb_req_addr = '0; bus.lsb_req_data = '0;
        bus.lsb_req_rob_id = '0; bus.if_req_flag = 1'b0; bus.if_req_addr = '0;

        repeat (3) @(negedge clk);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_mem_a", bus.mem_a, 32'd0);
        check("rst_flags", {28'd0, bus.lsb_done_flag, bus.ld_cdb_flag, bus.if_done_flag, 1'b0}, 32'd0);
        check("rst_cdb_val", bus.ld_cdb_val, 32'd0);
        check("rst_if_inst", bus.if_inst, 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.mem_wr || bus.lsb_done_flag || bus.ld_cdb_flag || bus.if_done_flag) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        lsb_op(WW, 1'b0, 1'b0, 32'h100, 32'h0, 32'd5, 0);
        check("lw_done_cycle", 32'(d_cycle), 32'd6);
        check("lw_cdb_flag", 32'(d_cdb), 32'd1);
        check("lw_cdb_rob", d_rob, 32'd5);
        check("lw_cdb_val", d_val, 32'h12345678);
        check("lw_one_done", 32'(n_done), 32'd1);

        lsb_op(WB, 1'b0, 1'b1, 32'h80, 32'h0, 32'd1, 0);
        check("lb_done_cycle", 32'(d_cycle), 32'd3);
        check("lb_sext_val", d_val, 32'hFFFFFF80);
        lsb_op(WB, 1'b0, 1'b0, 32'h80, 32'h0, 32'd2, 0);
        check("lbu_val", d_val, 32'h00000080);
        lsb_op(WH, 1'b0, 1'b0, 32'h8001, 32'h0, 32'd3, 0);
        check("lhu_done_cycle", 32'(d_cycle), 32'd4);
        check("lhu_val", d_val, 32'h00008001);
        lsb_op(WH, 1'b0, 1'b1, 32'h8001, 32'h0, 32'd4, 0);
        check("lh_sext_val", d_val, 32'hFFFF8001);

        lsb_op(WH, 1'b1, 1'b0, 32'h200, 32'hAABBCCDD, 32'd0, 0);
        check("sh_n_writes", 32'(n_wr), 32'd2);
        check("sh_w0_cycle", 32'(wr_cyc[0]), 32'd1);
        check("sh_w0_addr", wr_a[0], 32'h200);
        check("sh_w0_data", 32'(wr_d[0]), 32'hDD);
        check("sh_w1_cycle", 32'(wr_cyc[1]), 32'd2);
        check("sh_w1_addr", wr_a[1], 32'h201);
        check("sh_w1_data", 32'(wr_d[1]), 32'hCC);
        check("sh_done_cycle", 32'(d_cycle), 32'd3);
        check("sh_one_done", 32'(n_done), 32'd1);
        check("sh_no_cdb", 32'(n_cdb), 32'd0);

        lsb_op(WB, 1'b1, 1'b0, 32'h30000, 32'h0000005A, 32'd0, 4);
        check("io_n_writes", 32'(n_wr), 32'd1);
        check("io_w_cycle", 32'(wr_cyc[0]), 32'd5);
        check("io_w_addr", wr_a[0], 32'h30000);
        check("io_w_data", 32'(wr_d[0]), 32'h5A);
        check("io_done_cycle", 32'(d_cycle), 32'd6);

        lsb_op(WH, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, 32'd7, 0);
        check("wrap_a_c2", a_c2, 32'h0);
        check("wrap_done_cycle", 32'(d_cycle), 32'd4);
        check("wrap_val", d_val, 32'h000013F0);

        // LW and IF presented together: load first, fetch after one idle cycle.
        ld = -1; fd = -1; n_ifd = 0; d_val = '0; f_inst = '0;
        @(negedge clk);
        bus.lsb_req_flag = 1'b1; bus.lsb_req_width = WW; bus.lsb_req_type = 1'b0;
        bus.lsb_req_sext = 1'b0; bus.lsb_req_addr = 32'h40; bus.lsb_req_rob_id = 32'd9;
        bus.if_req_flag = 1'b1; bus.if_req_addr = 32'h0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.lsb_done_flag && ld < 0) begin ld = c; d_val = bus.ld_cdb_val; end
            if (bus.if_done_flag) begin
                n_ifd++;
                if (fd < 0) begin fd = c; f_inst = bus.if_inst; end
            end
            if (ld > 0 && c == ld + 1) bus.lsb_req_flag = 1'b0;
            if (fd == c) bus.if_req_flag = 1'b0;
        end
        bus.lsb_req_flag = 1'b0; bus.if_req_flag = 1'b0;
        check("arb_lw_cycle", 32'(ld), 32'd6);
        check("arb_lw_val", d_val, 32'hDEADBEEF);
        check("arb_if_cycle", 32'(fd), 32'd12);
        check("arb_if_inst", f_inst, 32'h00500513);
        check("arb_if_count", 32'(n_ifd), 32'd1);

        if_op(32'h100, 3);
        check("flush_mid_no_done", 32'(n_ifd), 32'd0);
        if_op(32'h100, 5);
        check("flush_last_no_done", 32'(n_ifd), 32'd0);
        if_op(32'h0, 0);
        check("if_done_cycle", 32'(fd), 32'd6);
        check("if_inst", f_inst, 32'h00500513);

        nrst = 0;
        @(negedge clk);
        bus.lsb_req_flag = 1'b1; bus.lsb_req_width = WW; bus.lsb_req_type = 1'b0;
        bus.lsb_req_addr = 32'h100; bus.lsb_req_rob_id = 32'd3;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (bus.lsb_done_flag || bus.ld_cdb_flag) nrst++;
            if (c == 3) begin rst = 1'b1; bus.lsb_req_flag = 1'b0; end
            if (c == 4) rst = 1'b0;
        end
        check("rst_abort_no_done", 32'(nrst), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
